// File: rtl/conv_ser_pkg.sv
// Shared types and constants for the conv-tree word serializer path.
package conv_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/conv_word_serializer_edge_tick.sv
// Samples a slow divided clock on the fast clock and flags its rising edges.
module edge_tick (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic tick_o
);

  logic sig_q;

  // Reset high so a divider that also resets high yields no spurious tick.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sig_q <= 1'b1;
    else        sig_q <= sig_i;
  end

  assign tick_o = sig_i & ~sig_q;

endmodule

// File: rtl/conv_word_serializer.sv
// Buffers parallel conv-tree words and shifts them out MSB-first, one bit per
// rising edge of the divided clock (sampled as data on clk_i).
module conv_word_serializer
  import conv_ser_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             slow_clk_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             ser_data_o,
  output logic             ser_frame_o,
  output logic             ser_active_o,
  output logic             word_done_o
);

  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic tick;

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] buf_data_q, buf_data_d;
  logic             buf_valid_q, buf_valid_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ser_q, ser_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;

  edge_tick u_edge_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sig_i  (slow_clk_i),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      ser_q       <= IDLE_LEVEL;
      frame_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_q       <= ser_d;
      frame_q     <= frame_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    ser_d       = ser_q;
    frame_d     = frame_q;
    done_d      = 1'b0;

    // Accept and load are exclusive: accept needs an empty buffer, load a full one.
    if (in_valid_i && !buf_valid_q) begin
      buf_data_d  = in_data_i;
      buf_valid_d = 1'b1;
    end

    if (tick) begin
      if (state_q == IDLE || bit_cnt_q == '0) begin
        done_d = (state_q == SHIFT);
        if (buf_valid_q) begin
          shreg_d     = buf_data_q;
          ser_d       = buf_data_q[WIDTH-1];
          frame_d     = 1'b1;
          bit_cnt_d   = CNT_LAST;
          state_d     = SHIFT;
          buf_valid_d = 1'b0;
        end else begin
          state_d = IDLE;
          ser_d   = IDLE_LEVEL;
          frame_d = 1'b0;
        end
      end else begin
        ser_d     = shreg_q[bit_cnt_q - CNT_ONE];
        bit_cnt_d = bit_cnt_q - CNT_ONE;
        frame_d   = 1'b0;
      end
    end
  end

  assign in_ready_o   = ~buf_valid_q;
  assign ser_data_o   = ser_q;
  assign ser_frame_o  = frame_q;
  assign ser_active_o = (state_q == SHIFT);
  assign word_done_o  = done_q;

endmodule

// File: tb/tb_conv_word_serializer.sv
// Self-checking bench for conv_word_serializer (WIDTH=8, tick every 4 clk_i cycles).
module tb_conv_word_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       slow_clk = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, ser, frame, active, done;
  bit         stall = 1'b0;
  int         dcnt = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conv_word_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .slow_clk_i   (slow_clk),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .ser_data_o   (ser),
    .ser_frame_o  (frame),
    .ser_active_o (active),
    .word_done_o  (done)
  );

  // Clock divider, DIVISIONS=2: slow clock period of 4 clk cycles, resets high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_clk <= 1'b1;
      dcnt     <= 0;
    end else if (stall) begin
      slow_clk <= 1'b0;
      dcnt     <= 0;
    end else if (dcnt == 1) begin
      slow_clk <= ~slow_clk;
      dcnt     <= 0;
    end else begin
      dcnt <= dcnt + 1;
    end
  end

  // Reference model: a one-word buffer feeding a queue of pending bits.
  bit         m_slow_q = 1'b1;
  bit         m_full = 1'b0;
  bit         m_active = 1'b0;
  bit         m_tick = 1'b0;
  logic [7:0] m_buf = '0;
  bit         m_rem[$];
  logic       e_ser = 1'b0;
  logic       e_frame = 1'b0;
  logic       e_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_slow_q = 1'b1; m_full = 1'b0; m_active = 1'b0; m_tick = 1'b0;
      m_rem.delete();
      e_ser = 1'b0; e_frame = 1'b0; e_done = 1'b0;
    end else begin
      bit tk, acc;
      tk       = slow_clk & ~m_slow_q;
      m_slow_q = slow_clk;
      acc      = in_valid & ~m_full;
      e_done   = 1'b0;
      m_tick   = tk;
      if (tk) begin
        if (m_rem.size() == 0) begin
          e_done = m_active;
          if (m_full) begin
            for (int i = 7; i >= 0; i--) m_rem.push_back(m_buf[i]);
            e_ser = m_rem.pop_front(); e_frame = 1'b1; m_active = 1'b1; m_full = 1'b0;
          end else begin
            m_active = 1'b0; e_ser = 1'b0; e_frame = 1'b0;
          end
        end else begin
          e_ser = m_rem.pop_front(); e_frame = 1'b0;
        end
      end
      if (acc) begin
        m_buf  = in_data;
        m_full = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model plus a tick-sampled output log.
  logic [2:0] mon_q[$];
  int         done_cnt = 0;
  int         acc_cnt = 0;

  always @(negedge clk) begin
    check("cycle{rdy,ser,frm,act,done}", 32'({in_ready, ser, frame, active, done}),
          32'({~m_full, e_ser, e_frame, m_active, e_done}));
    if (m_tick) mon_q.push_back({active, frame, ser});
    if (done) done_cnt++;
    if (in_valid && in_ready) acc_cnt++;
  end

  task automatic send(input logic [7:0] w, input bit keep);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 400; i++) begin
      if (in_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("send_timeout", 32'd1, 32'd0);
    if (!keep) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    for (int i = 0; i < 40 * n + 40 && seen < n; i++) begin
      @(negedge clk);
      if (m_tick) seen++;
    end
    if (seen < n) check("tick_timeout", 32'(seen), 32'(n));
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!active && in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Collect n tick samples starting at the first active one.
  task automatic extract(input int n, output logic [31:0] bits, output logic [31:0] frms,
                         output logic [31:0] acts);
    int s = -1;
    bits = '0; frms = '0; acts = '0;
    for (int i = 0; i < mon_q.size(); i++)
      if (mon_q[i][2]) begin s = i; break; end
    if (s < 0 || s + n > mon_q.size()) begin
      bits = 'x; frms = 'x; acts = 'x;
      return;
    end
    for (int i = 0; i < n; i++) begin
      bits = {bits[30:0], mon_q[s+i][0]};
      frms = {frms[30:0], mon_q[s+i][1]};
      acts = {acts[30:0], mon_q[s+i][2]};
    end
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_bits;
    logic [7:0] exp_frame;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] b, f, a;
    logic [7:0]  w0, w1, w2;
    logic        held;
    bit          stable;

    vecs[0] = '{8'hA5, 8'b1010_0101, 8'b1000_0000};
    vecs[1] = '{8'h3C, 8'b0011_1100, 8'b1000_0000};
    vecs[2] = '{8'h01, 8'b0000_0001, 8'b1000_0000};
    vecs[3] = '{8'h80, 8'b1000_0000, 8'b1000_0000};
    vecs[4] = '{8'hFF, 8'b1111_1111, 8'b1000_0000};
    vecs[5] = '{8'h00, 8'b0000_0000, 8'b1000_0000};

    // Reset and quiet period
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    @(negedge clk);
    check("reset_state{rdy,ser,act}", 32'({in_ready, ser, active}), 32'b100);
    repeat (20) @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt), 32'd0);

    // Single words from the table
    foreach (vecs[k]) begin
      wait_idle();
      mon_q.delete();
      done_cnt = 0;
      send(vecs[k].word, 1'b0);
      wait_ticks(10);
      extract(9, b, f, a);
      check($sformatf("bits_%02h", vecs[k].word), b, 32'({vecs[k].exp_bits, 1'b0}));
      check($sformatf("frame_%02h", vecs[k].word), f, 32'({vecs[k].exp_frame, 1'b0}));
      check($sformatf("active_%02h", vecs[k].word), a, 32'b1_1111_1110);
      check($sformatf("done_cnt_%02h", vecs[k].word), 32'(done_cnt), 32'd1);
    end

    // Back-to-back words: no idle slot in between
    wait_idle();
    mon_q.delete();
    done_cnt = 0;
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    wait_ticks(20);
    extract(17, b, f, a);
    check("b2b_bits", b, 32'({16'hFF00, 1'b0}));
    check("b2b_frame", f, 32'({16'h8080, 1'b0}));
    check("b2b_done_cnt", 32'(done_cnt), 32'd2);

    // Backpressure: valid held high across three words
    wait_idle();
    mon_q.delete();
    done_cnt = 0;
    acc_cnt = 0;
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
    send(w0, 1'b1);
    send(w1, 1'b1);
    send(w2, 1'b0);
    wait_ticks(30);
    extract(25, b, f, a);
    check("bp_stream", b, 32'({w0, w1, w2, 1'b0}));
    check("bp_accepts", 32'(acc_cnt), 32'd3);
    check("bp_done_cnt", 32'(done_cnt), 32'd3);

    // Stall the divided clock mid-word
    wait_idle();
    mon_q.delete();
    send(8'hC3, 1'b0);
    wait_ticks(4);
    stall = 1'b1;
    @(negedge clk);
    held = ser;
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (ser !== held || active !== 1'b1) stable = 1'b0;
    end
    check("stall_hold", 32'(stable), 32'd1);
    stall = 1'b0;
    wait_ticks(8);
    extract(9, b, f, a);
    check("stall_stream", b, 32'({8'hC3, 1'b0}));

    // Asynchronous reset mid-word with a word buffered
    wait_idle();
    send(8'h3C, 1'b0);
    wait_ticks(1);
    send(8'h5A, 1'b0);
    wait_ticks(3);
    check("pre_reset_busy{rdy,act}", 32'({in_ready, active}), 32'b01);
    #2 rst_n = 1'b0;
    #1 check("async_reset{rdy,ser,frm,act,done}", 32'({in_ready, ser, frame, active, done}),
             32'b10000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (active !== 1'b0 || ser !== 1'b0 || done !== 1'b0) stable = 1'b0;
    end
    check("no_stale_after_reset", 32'(stable), 32'd1);

    // Randomized traffic with occasional stalls, checked cycle by cycle
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      if ($urandom_range(0, 99) < 2) stall = ~stall;
      @(negedge clk);
    end
    stall = 1'b0;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/conv_word_serializer.md
Name: conv_word_serializer

Overview:
- Sits directly downstream of the clock divider in the conv-tree serializer path.
- Accepts parallel result words from the conv tree over a valid/ready handshake.
- Shifts each word out MSB-first, one bit per rising edge of the divided clock. The divided clock is sampled as a data signal in the fast clock domain; it is never used as a clock.
- Holds one word in a buffer so the tree can hand over the next word while the current one is being shifted.

Parameters:
- WIDTH, 16, bits per word; legal range 2..1024.
- IDLE_LEVEL, 1'b0, ser_data_o value while no word is being shifted.

Ports:
- clk_i  input  1  fast system clock; the only clock.
- rst_i  input  1  asynchronous, active-low reset.
- slow_clk_i  input  1  divided clock from the clock divider, sampled on clk_i.
- in_data_i  input  WIDTH  parallel word from the conv tree.
- in_valid_i  input  1  in_data_i is valid.
- in_ready_o  output  1  the buffer can accept a word.
- ser_data_o  output  1  serial bit, MSB first.
- ser_frame_o  output  1  high while ser_data_o carries bit WIDTH-1 of a word.
- ser_active_o  output  1  high while a word is being shifted.
- word_done_o  output  1  one-cycle pulse when the last bit of a word has been presented for a full slow period.

Behaviour:
- Reset (rst_i low, asynchronous):
  - slow_q=1, so the divider's reset-high clock gives no spurious tick.
  - buf_valid=0, active=0, bit_cnt=0, shreg=0.
  - Outputs: ser_data_o=IDLE_LEVEL, ser_frame_o=0, ser_active_o=0, word_done_o=0, in_ready_o=1.
- Tick detect: slow_q is slow_clk_i registered on clk_i. tick = slow_clk_i & ~slow_q (rising-edge detect).
- Input handshake:
  - in_ready_o = ~buf_valid, registered-state only, so no combinational path from tick.
  - Transfer happens when in_valid_i & in_ready_o: buf_data<=in_data_i, buf_valid<=1.
  - No same-cycle refill: while buf_valid=1, in_ready_o=0, even in the cycle the buffer drains.
- State: IDLE (active=0) and SHIFT (active=1). All transitions happen only on tick; between ticks every output holds.
- On tick, when in IDLE, or in SHIFT with bit_cnt==0:
  - if buf_valid=1: load. shreg<=buf_data, ser_data_o<=buf_data[WIDTH-1], ser_frame_o<=1, bit_cnt<=WIDTH-1, active<=1, buf_valid<=0.
  - else: active<=0, ser_data_o<=IDLE_LEVEL, ser_frame_o<=0.
  - in either case, if the previous state was SHIFT, word_done_o<=1 for one cycle.
- On tick, in SHIFT with bit_cnt>0: ser_data_o<=shreg[bit_cnt-1], bit_cnt<=bit_cnt-1, ser_frame_o<=0.
- ser_active_o = active.
- Back-to-back words: no idle slot. Bit 0 of word N is followed on the next tick by bit WIDTH-1 of word N+1, with ser_frame_o high again.
- Latency: the first bit appears one clk_i cycle after the first tick that follows the cycle in which buf_valid became 1.
- bit_cnt width is $clog2(WIDTH). Decrement never wraps because it is guarded by bit_cnt>0.
- Simultaneous input accept and tick: the accept writes the buffer. The load uses the pre-accept buf_valid, so the word is shifted starting at the following tick.
- slow_clk_i stuck at either level: no ticks, state and outputs hold indefinitely.
- Reset mid-word: the word in flight and the buffered word are dropped; outputs return to reset values immediately.
- Data is registered at accept; in_data_i changing after acceptance has no effect.

Decomposition:
- Shared package conv_ser_pkg: ser_state_e {IDLE, SHIFT}; localparam function for counter width (clog2 of WIDTH); IDLE_LEVEL default constant.
- Sub-module edge_tick: sampler plus rising-edge detect with reset value 1. The same sampler is reused by other consumers of the divided clock.

Test Plan:
- Setup for all scenarios: WIDTH=8, clock divider with DIVISIONS=2 drives slow_clk_i, giving a tick every 4 clk_i cycles.
- Reset: hold rst_i low, then release -> ser_data_o=0, ser_active_o=0, in_ready_o=1. No word_done_o pulse during the first 20 cycles with no input.
- Single word: send 8'hA5 -> bits 1,0,1,0,0,1,0,1 on successive ticks, each held for 4 cycles. ser_frame_o high only during the first bit. word_done_o pulses once at the 9th tick, and ser_data_o then returns to 0.
- Back-to-back: send 8'hFF, then 8'h00 while the first is shifting -> 16 contiguous bits, 8 ones then 8 zeros. ser_frame_o high at bit 0 and at bit 8. in_ready_o stays 0 from the second accept until the second word loads.
- Backpressure: hold in_valid_i high with 3 words -> exactly one accept per load. Word order is preserved and no word is lost or duplicated.
- Stall: force slow_clk_i to 0 mid-word for 50 cycles -> ser_data_o and bit_cnt frozen. On resume, shifting continues from the next bit.
- Async reset mid-word: assert rst_i at bit 3 of 8'h3C with a word buffered -> outputs return to reset values in the same cycle. After release, no stale bits appear.
